// File: rtl/parity_pkg.sv
// Shared types for the parity frame controller.
// Latency: n/a (types only).
// Backpressure: n/a.
package parity_pkg;

    // Frame controller states: IDLE waits for start, DATA takes payload bytes,
    // TRAIL takes the single trailer byte, DONE pulses for one cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        TRAIL = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/detects_odd_number_of_ones.sv
// Flags a byte whose population count is odd.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input.
//
// Ports:
//   data : byte under test
//   odd  : 1 when data contains an odd number of ones
module detects_odd_number_of_ones (
    input  logic [7:0] data,
    output logic       odd
);

    assign odd = ^data;

endmodule

// File: rtl/parity_frame_ctrl.sv
// Accepts a length-prefixed frame of bytes plus one trailer byte and reports per-frame parity stats.
// Latency: done pulses one cycle after the trailer transfer; parity is folded in on the transfer edge.
// Backpressure: in_ready high in DATA/TRAIL; in_valid low stalls the frame indefinitely.
//
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   start, len          : begin a frame of len data bytes (sampled in IDLE only)
//   abort               : drop the current frame back to IDLE, no done pulse
//   in_valid, in_data   : byte input; transfers when in_valid && in_ready
//   in_ready, busy      : accepting a byte / not idle
//   done                : one-cycle completion pulse
//   frame_odd, odd_cnt  : XOR of byte parities / number of odd-parity bytes
//   err                 : trailer did not equal {7'b0, frame_odd}
module parity_frame_ctrl
    import parity_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             frame_odd,
    output logic [LEN_W-1:0] odd_cnt,
    output logic             err
);

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] remaining;
    logic             byte_odd;
    logic             xfer;

    detects_odd_number_of_ones u_odd (
        .data (in_data),
        .odd  (byte_odd)
    );

    assign in_ready = (state == DATA) || (state == TRAIL);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    // Abort wins over a same-cycle handshake: the byte is left unconsumed.
    assign xfer = in_valid && in_ready && !abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len != '0) ? DATA : TRAIL;
                end
            end
            DATA: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (xfer && remaining == LEN_W'(1)) begin
                    state_nxt = TRAIL;
                end
            end
            TRAIL: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (xfer) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Accumulators are cleared only by reset or a new start, so results
    // (and partial results after abort) stay visible while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
            frame_odd <= 1'b0;
            odd_cnt   <= '0;
            err       <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                remaining <= len;
                frame_odd <= 1'b0;
                odd_cnt   <= '0;
                err       <= 1'b0;
            end
        end else if (xfer && state == DATA) begin
            frame_odd <= frame_odd ^ byte_odd;
            // Cannot wrap: at most len (< 2**LEN_W) increments per frame.
            odd_cnt   <= odd_cnt + {{(LEN_W-1){1'b0}}, byte_odd};
            remaining <= remaining - LEN_W'(1);
        end else if (xfer && state == TRAIL) begin
            err <= (in_data[0] != frame_odd) || (in_data[7:1] != 7'd0);
        end
    end

endmodule

// File: tb/tb_parity_frame_ctrl.sv
module tb_parity_frame_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] len_i;
    logic       abort;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic       frame_odd;
    logic [3:0] odd_cnt;
    logic       err;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0] fb [16];

    parity_frame_ctrl #(.LEN_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len_i),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .busy      (busy),
        .done      (done),
        .frame_odd (frame_odd),
        .odd_cnt   (odd_cnt),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [31:0] b;   // byte i at b[8*i +: 8]
        logic [7:0]  tr;
        int          sa;  // stall before byte sa (-1 = none)
        int          sl;  // stall length in cycles
        logic        eo;
        int          ec;
        logic        ee;
    } vec_t;

    vec_t tbl [7];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: frame parity from the total count of ones,
    // odd count from per-byte population counts.
    function automatic logic ref_par(input int upto);
        int ones = 0;
        for (int i = 0; i < upto; i++) ones += $countones(fb[i]);
        return (ones % 2) == 1;
    endfunction

    function automatic int ref_cnt(input int upto);
        int c = 0;
        for (int i = 0; i < upto; i++) if (($countones(fb[i]) % 2) == 1) c++;
        return c;
    endfunction

    task automatic do_frame(input string tag, input int n, input logic [7:0] tr,
                            input int sa, input int sl,
                            input logic eo, input int ec, input logic ee);
        int cyc;
        int exp_cyc;
        start = 1'b1;
        len_i = 4'(n);
        tick();
        start = 1'b0;
        len_i = 4'd0;
        cyc = 1;
        chk({tag, ".busy_start"}, busy, 1);
        for (int i = 0; i < n; i++) begin
            if (i == sa) begin
                in_valid = 1'b0;
                for (int s = 0; s < sl; s++) begin
                    tick();
                    cyc++;
                    chk({tag, ".stall_busy"}, busy, 1);
                    chk({tag, ".stall_cnt"}, odd_cnt, ref_cnt(i));
                    chk({tag, ".stall_odd"}, frame_odd, ref_par(i));
                    chk({tag, ".stall_done"}, done, 0);
                end
            end
            chk({tag, ".ready"}, in_ready, 1);
            chk({tag, ".early_done"}, done, 0);
            in_valid = 1'b1;
            in_data  = fb[i];
            tick();
            cyc++;
        end
        chk({tag, ".trail_ready"}, in_ready, 1);
        in_valid = 1'b1;
        in_data  = tr;
        tick();
        cyc++;
        in_valid = 1'b0;
        in_data  = 8'h00;
        exp_cyc = n + 2 + ((sa >= 0 && sa < n) ? sl : 0);
        chk({tag, ".done"}, done, 1);
        chk({tag, ".cycles"}, cyc, exp_cyc);
        chk({tag, ".frame_odd"}, frame_odd, eo);
        chk({tag, ".odd_cnt"}, odd_cnt, ec);
        chk({tag, ".err"}, err, ee);
        tick();
        chk({tag, ".done_clr"}, done, 0);
        chk({tag, ".idle"}, busy, 0);
        chk({tag, ".hold_odd"}, frame_odd, eo);
        chk({tag, ".hold_cnt"}, odd_cnt, ec);
        chk({tag, ".hold_err"}, err, ee);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        len_i    = 4'd0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int i = 0; i < 16; i++) fb[i] = 8'h00;

        tick();
        tick();
        chk("rst.in_ready", in_ready, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.frame_odd", frame_odd, 0);
        chk("rst.odd_cnt", odd_cnt, 0);
        chk("rst.err", err, 0);
        rst = 1'b0;
        tick();

        // Directed table: n, bytes, trailer, stall_at, stall_len, frame_odd, odd_cnt, err
        tbl[0] = '{2, 32'h0000_3733, 8'h01, -1, 0, 1'b1, 1, 1'b0};
        tbl[1] = '{1, 32'h0000_0013, 8'h00, -1, 0, 1'b1, 1, 1'b1};
        tbl[2] = '{0, 32'h0000_0000, 8'h00, -1, 0, 1'b0, 0, 1'b0};
        tbl[3] = '{3, 32'h0004_0201, 8'h01, -1, 0, 1'b1, 3, 1'b0};
        tbl[4] = '{2, 32'h0000_00FF, 8'h02, -1, 0, 1'b0, 0, 1'b1};
        tbl[5] = '{4, 32'h0380_0F07, 8'h00, -1, 0, 1'b0, 2, 1'b0};
        tbl[6] = '{3, 32'h0070_1011, 8'h01,  1, 5, 1'b0, 2, 1'b1};
        for (int t = 0; t < 7; t++) begin
            for (int i = 0; i < 4; i++) fb[i] = tbl[t].b[8*i +: 8];
            do_frame($sformatf("tbl%0d", t), tbl[t].n, tbl[t].tr, tbl[t].sa, tbl[t].sl,
                     tbl[t].eo, tbl[t].ec, tbl[t].ee);
        end

        // Abort during the 2nd data byte: byte not consumed, no done.
        fb[0] = 8'h01;
        start = 1'b1; len_i = 4'd3; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = fb[0]; tick();
        in_data = 8'h03; abort = 1'b1; tick();
        abort = 1'b0; in_valid = 1'b0;
        chk("abort.busy", busy, 0);
        chk("abort.in_ready", in_ready, 0);
        chk("abort.done", done, 0);
        chk("abort.odd_cnt", odd_cnt, 1);
        chk("abort.frame_odd", frame_odd, 1);
        tick();
        chk("abort.no_done_later", done, 0);
        // Abort in IDLE has no effect.
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_idle.busy", busy, 0);
        chk("abort_idle.odd_cnt", odd_cnt, 1);

        // start while in DATA is ignored (len not recaptured).
        start = 1'b1; len_i = 4'd1; tick();
        len_i = 4'd5; in_valid = 1'b1; in_data = 8'h01; tick();
        start = 1'b0; len_i = 4'd0;
        chk("start_ign.trail_ready", in_ready, 1);
        in_data = 8'h01; tick(); in_valid = 1'b0;
        chk("start_ign.done", done, 1);
        chk("start_ign.odd_cnt", odd_cnt, 1);
        chk("start_ign.err", err, 0);
        tick();

        // Reset while in TRAIL with a trailer on the bus.
        start = 1'b1; len_i = 4'd1; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 8'h01; tick();
        chk("rst_mid.in_trail", in_ready, 1);
        rst = 1'b1; in_data = 8'h01; tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_mid.in_ready", in_ready, 0);
        chk("rst_mid.busy", busy, 0);
        chk("rst_mid.done", done, 0);
        chk("rst_mid.frame_odd", frame_odd, 0);
        chk("rst_mid.odd_cnt", odd_cnt, 0);
        chk("rst_mid.err", err, 0);
        fb[0] = 8'h07; fb[1] = 8'h01;
        do_frame("after_rst", 2, 8'h00, -1, 0, 1'b0, 2, 1'b0);

        // Randomized frames checked against the reference model.
        for (int r = 0; r < 40; r++) begin
            int n;
            int sa;
            int sl;
            logic eo;
            logic [7:0] tr;
            n = $urandom_range(0, 15);
            for (int i = 0; i < n; i++) fb[i] = 8'($urandom);
            eo = ref_par(n);
            tr = ($urandom_range(0, 1) == 1) ? {7'd0, eo} : 8'($urandom_range(0, 255));
            sa = (n > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
            sl = $urandom_range(1, 4);
            do_frame($sformatf("rnd%0d", r), n, tr, sa, sl, eo, ref_cnt(n),
                     tr != {7'd0, eo});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
